// File: rtl/interrupt_controller_n.sv
// NUM_SRC-source interrupt controller: synchronised edge detection, pending latches, enable mask,
// fixed lowest-index priority and a REQ/ATTEND handshake. Define INTC_LEVEL_MODE_EN for per-source level mode.
module interrupt_controller_n #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_WEnable,
  input  logic [31:0]        i_WAddr,
  input  logic [31:0]        i_WData,
  input  logic               i_REnable,
  input  logic [31:0]        i_RAddr,
  output logic [31:0]        o_RData,
  output logic               o_Err,
  input  logic [NUM_SRC-1:0] i_IntSrc,
  input  logic               i_AckAttended,
  input  logic               i_AckComplete,
  output logic               o_IntPending,
  output logic               o_IntAttending,
  output logic               o_IrqReq,
  output logic [ID_W-1:0]    o_IrqNumber
);

  localparam logic [31:0] ADDR_CTRL    = 32'h0;
  localparam logic [31:0] ADDR_ENABLE  = 32'h1;
  localparam logic [31:0] ADDR_PENDING = 32'h2;
  localparam logic [31:0] ADDR_STATUS  = 32'h3;
`ifdef INTC_LEVEL_MODE_EN
  localparam logic [31:0] ADDR_MODE    = 32'h4;
`endif

  typedef enum logic [1:0] {IDLE, REQ, ATTEND} state_t;

  state_t             state;
  logic               ea;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] src_p0;
  logic [NUM_SRC-1:0] src_p1;
  logic [NUM_SRC-1:0] src_p2;

  logic               wr_ctrl;
  logic               wr_enable;
  logic [NUM_SRC-1:0] wr_clr;
  logic               wr_bad;
  logic [31:0]        rd_val;
  logic               rd_bad;
  logic               ea_next;
  logic [NUM_SRC-1:0] enable_next;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] set_mask;
  logic [NUM_SRC-1:0] pending_next;
  logic               withdraw;
  logic               unused_wdata;

  assign unused_wdata = ^i_WData;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

`ifdef INTC_LEVEL_MODE_EN
  logic wr_mode;
`else
  assign mode = '0;
`endif

  always_comb begin
    wr_ctrl   = 1'b0;
    wr_enable = 1'b0;
    wr_clr    = '0;
    wr_bad    = 1'b0;
`ifdef INTC_LEVEL_MODE_EN
    wr_mode   = 1'b0;
`endif
    if (i_WEnable) begin
      case (i_WAddr)
        ADDR_CTRL:    wr_ctrl   = 1'b1;
        ADDR_ENABLE:  wr_enable = 1'b1;
        ADDR_PENDING: wr_clr    = i_WData[NUM_SRC-1:0];
`ifdef INTC_LEVEL_MODE_EN
        ADDR_MODE:    wr_mode   = 1'b1;
`endif
        default:      wr_bad    = 1'b1;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    rd_bad = 1'b0;
    case (i_RAddr)
      ADDR_CTRL:    rd_val[0] = ea;
      ADDR_ENABLE:  rd_val[NUM_SRC-1:0] = enable;
      ADDR_PENDING: rd_val[NUM_SRC-1:0] = pending;
      ADDR_STATUS: begin
        rd_val[31]       = o_IrqReq;
        rd_val[30]       = o_IntAttending;
        rd_val[ID_W-1:0] = o_IrqNumber;
      end
`ifdef INTC_LEVEL_MODE_EN
      ADDR_MODE:    rd_val[NUM_SRC-1:0] = mode;
`endif
      default:      rd_bad = 1'b1;
    endcase
  end

  // Next-cycle register view, so a REQ withdraws in the same edge as the offending write
  always_comb begin
    ea_next      = wr_ctrl ? i_WData[0] : ea;
    enable_next  = wr_enable ? i_WData[NUM_SRC-1:0] : enable;
    ack_clr      = (state == REQ && i_AckAttended) ? (NUM_SRC'(1) << o_IrqNumber) : '0;
    set_mask     = (src_p1 & ~src_p2 & ~mode) | (src_p1 & mode);
    pending_next = (pending & ~(wr_clr | ack_clr)) | set_mask;
    withdraw     = !ea_next || !pending_next[o_IrqNumber] || !enable_next[o_IrqNumber];
  end

  // Bus register stage
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      ea      <= 1'b0;
      enable  <= '0;
      o_RData <= '0;
      o_Err   <= 1'b0;
    end else begin
      ea     <= ea_next;
      enable <= enable_next;
      if (i_WEnable) begin
        o_Err <= wr_bad;
      end else if (i_REnable) begin
        o_Err <= rd_bad;
        if (!rd_bad) o_RData <= rd_val;
      end else begin
        o_Err <= 1'b0;
      end
    end
  end

`ifdef INTC_LEVEL_MODE_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) mode <= '0;
    else if (wr_mode) mode <= i_WData[NUM_SRC-1:0];
  end
`endif

  // Source synchroniser (p0, p1), edge history (p2) and pending latch stage
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      src_p0       <= '0;
      src_p1       <= '0;
      src_p2       <= '0;
      pending      <= '0;
      o_IntPending <= 1'b0;
    end else begin
      src_p0       <= i_IntSrc;
      src_p1       <= src_p0;
      src_p2       <= src_p1;
      pending      <= pending_next;
      o_IntPending <= |(pending & enable);
    end
  end

  // Handshake FSM stage
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state          <= IDLE;
      o_IrqReq       <= 1'b0;
      o_IntAttending <= 1'b0;
      o_IrqNumber    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ea && |(pending & enable)) begin
            o_IrqNumber <= lowest_idx(pending & enable);
            o_IrqReq    <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (i_AckAttended) begin
            o_IrqReq <= 1'b0;
            if (i_AckComplete) begin
              state <= IDLE;
            end else begin
              o_IntAttending <= 1'b1;
              state          <= ATTEND;
            end
          end else if (withdraw) begin
            o_IrqReq <= 1'b0;
            state    <= IDLE;
          end
        end
        ATTEND: begin
          if (i_AckComplete) begin
            o_IntAttending <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          o_IrqReq       <= 1'b0;
          o_IntAttending <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller_n.sv
// Bench for interrupt_controller_n: register table, handshake sequences and a bus-response scoreboard.
module tb_interrupt_controller_n;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;

  logic              clk;
  logic              rst;
  logic              wen;
  logic [31:0]       waddr;
  logic [31:0]       wdata;
  logic              ren;
  logic [31:0]       raddr;
  logic [31:0]       rdata;
  logic              err;
  logic [NUM_SRC-1:0] src;
  logic              ack_att;
  logic              ack_comp;
  logic              int_pending;
  logic              int_attending;
  logic              irq_req;
  logic [ID_W-1:0]   irq_number;

  interrupt_controller_n #(.NUM_SRC(NUM_SRC)) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_WEnable      (wen),
    .i_WAddr        (waddr),
    .i_WData        (wdata),
    .i_REnable      (ren),
    .i_RAddr        (raddr),
    .o_RData        (rdata),
    .o_Err          (err),
    .i_IntSrc       (src),
    .i_AckAttended  (ack_att),
    .i_AckComplete  (ack_comp),
    .o_IntPending   (int_pending),
    .o_IntAttending (int_attending),
    .o_IrqReq       (irq_req),
    .o_IrqNumber    (irq_number)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } resp_t;

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  resp_t       exp_q[$];
  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd = '0;
  logic        resp_due = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] rd, input logic e);
    vec_t v;
    v.w = w; v.r = r; v.addr = addr; v.data = data; v.rd = rd; v.err = e;
    return v;
  endfunction

  always @(posedge clk) resp_due <= (wen || ren) && !rst;

  always @(negedge clk) begin
    if (resp_due) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: response with no expectation queued");
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("bus_rdata", rdata, e.rd);
        check("bus_err", {31'b0, err}, {31'b0, e.err});
      end
    end
  end

  // All tasks start and end just after a negedge
  task automatic bus_op(input logic w, input logic r, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_err);
    resp_t e;
    wen = w; ren = r; waddr = addr; raddr = addr; wdata = data;
    if (r && !w && !exp_err) last_rd = exp_rd;
    e.rd  = last_rd;
    e.err = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic ack(input logic a, input logic c);
    ack_att = a; ack_comp = c;
    @(negedge clk);
    ack_att = 1'b0; ack_comp = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input logic [NUM_SRC-1:0] pulse, input int exp_lat,
                          input logic [ID_W-1:0] exp_id, input string name);
    int n;
    n = 0;
    src = pulse;
    while (n < 12 && !irq_req) begin
      @(negedge clk);
      n++;
      if (n == 1) src = '0;
    end
    check({name, "_latency"}, n, exp_lat);
    check({name, "_req"}, {31'b0, irq_req}, 32'd1);
    check({name, "_id"}, {29'b0, irq_number}, {29'b0, exp_id});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0; rst = 1'b1; wen = 1'b0; ren = 1'b0; waddr = '0; raddr = '0; wdata = '0;
    src = '0; ack_att = 1'b0; ack_comp = 1'b0;
    cycles(3);
    check("reset_rdata", rdata, 32'h0);
    check("reset_flags", {27'b0, err, int_pending, int_attending, irq_req, 1'b0},
          32'h0);
    check("reset_id", {29'b0, irq_number}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    vecs.push_back(mk(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h1, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h2, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h3, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h5, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h3, 32'h1, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h1000_0000, 32'h1, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0, 32'h0, 32'h1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h1, 32'h0, 32'hFF, 1'b0));
`ifdef INTC_LEVEL_MODE_EN
    vecs.push_back(mk(1'b0, 1'b1, 32'h4, 32'h0, 32'h0, 1'b0));
`else
    vecs.push_back(mk(1'b1, 1'b0, 32'h4, 32'h1, 32'h0, 1'b1));
`endif
    vecs.push_back(mk(1'b0, 1'b1, 32'h3, 32'h0, 32'h0, 1'b0));
    foreach (vecs[i]) bus_op(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].data, vecs[i].rd, vecs[i].err);

    // Single source: latency, status, attend, complete
    wait_req(8'h20, 4, 3'd5, "src5");
    check("src5_intpending", {31'b0, int_pending}, 32'd1);
    bus_op(1'b0, 1'b1, 32'h3, 32'h0, 32'h8000_0005, 1'b0);
    bus_op(1'b0, 1'b1, 32'h2, 32'h0, 32'h20, 1'b0);
    ack(1'b1, 1'b0);
    check("src5_attending", {30'b0, int_attending, irq_req}, 32'h2);
    bus_op(1'b0, 1'b1, 32'h2, 32'h0, 32'h0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h3, 32'h0, 32'h4000_0005, 1'b0);
    check("src5_intpending_cleared", {31'b0, int_pending}, 32'd0);
    ack(1'b0, 1'b1);
    check("src5_done", {29'b0, int_pending, int_attending, irq_req}, 32'h0);
    check("src5_id_hold", {29'b0, irq_number}, 32'd5);

    // Two sources together: priority and one IDLE cycle between requests
    wait_req(8'h44, 4, 3'd2, "src2");
    ack(1'b1, 1'b0);
    ack(1'b0, 1'b1);
    check("gap_idle", {30'b0, int_attending, irq_req}, 32'h0);
    @(negedge clk);
    check("src6_req", {31'b0, irq_req}, 32'd1);
    check("src6_id", {29'b0, irq_number}, 32'd6);
    ack(1'b1, 1'b1);
    check("src6_direct_idle", {30'b0, int_attending, irq_req}, 32'h0);
    bus_op(1'b0, 1'b1, 32'h2, 32'h0, 32'h0, 1'b0);

    // W1C of the requested bit withdraws
    wait_req(8'h08, 4, 3'd3, "src3");
    bus_op(1'b1, 1'b0, 32'h2, 32'h08, 32'h0, 1'b0);
    check("w1c_withdraw", {31'b0, irq_req}, 32'd0);
    cycles(3);
    check("w1c_no_rereq", {31'b0, irq_req}, 32'd0);
    bus_op(1'b0, 1'b1, 32'h2, 32'h0, 32'h0, 1'b0);

    // Masked source latches pending; enabling it raises the request; EA withdraw and retry
    bus_op(1'b1, 1'b0, 32'h1, 32'h00, 32'h0, 1'b0);
    src = 8'h02;
    @(negedge clk);
    src = '0;
    cycles(4);
    check("masked_no_req", {31'b0, irq_req}, 32'd0);
    check("masked_intpending", {31'b0, int_pending}, 32'd0);
    bus_op(1'b0, 1'b1, 32'h2, 32'h0, 32'h02, 1'b0);
    bus_op(1'b1, 1'b0, 32'h1, 32'h02, 32'h0, 1'b0);
    wait_req('0, 1, 3'd1, "src1_enabled");
    bus_op(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("ea_withdraw", {31'b0, irq_req}, 32'd0);
    @(negedge clk);
    check("ea_off_no_req", {31'b0, irq_req}, 32'd0);
    bus_op(1'b1, 1'b0, 32'h0, 32'h1, 32'h0, 1'b0);
    wait_req('0, 1, 3'd1, "src1_ea_on");
    ack(1'b1, 1'b1);
    bus_op(1'b0, 1'b1, 32'h2, 32'h0, 32'h0, 1'b0);

    // Write and read in the same cycle: write wins, read dropped
    bus_op(1'b1, 1'b1, 32'h1, 32'h0F, 32'h0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h1, 32'h0, 32'h0F, 1'b0);

    // Held-high source 0 with bit 0 masked
    bus_op(1'b1, 1'b0, 32'h1, 32'h0E, 32'h0, 1'b0);
`ifdef INTC_LEVEL_MODE_EN
    bus_op(1'b1, 1'b0, 32'h4, 32'h01, 32'h0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h4, 32'h0, 32'h01, 1'b0);
    src = 8'h01;
    cycles(4);
    bus_op(1'b1, 1'b0, 32'h2, 32'h01, 32'h0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h2, 32'h0, 32'h01, 1'b0);
    src = '0;
    cycles(3);
    bus_op(1'b1, 1'b0, 32'h2, 32'h01, 32'h0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h2, 32'h0, 32'h00, 1'b0);
`else
    src = 8'h01;
    cycles(4);
    bus_op(1'b0, 1'b1, 32'h2, 32'h0, 32'h01, 1'b0);
    bus_op(1'b1, 1'b0, 32'h2, 32'h01, 32'h0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h2, 32'h0, 32'h00, 1'b0);
    src = '0;
    cycles(3);
`endif

    // Reset in the middle of a request
    bus_op(1'b1, 1'b0, 32'h1, 32'hFF, 32'h0, 1'b0);
    wait_req(8'h10, 4, 3'd4, "src4");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    check("midreset_flags", {29'b0, int_pending, int_attending, irq_req}, 32'h0);
    check("midreset_id", {29'b0, irq_number}, 32'h0);
    check("midreset_rdata", rdata, 32'h0);
    bus_op(1'b0, 1'b1, 32'h1, 32'h0, 32'h0, 1'b0);
    bus_op(1'b0, 1'b1, 32'h2, 32'h0, 32'h0, 1'b0);

    cycles(2);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
